conv1_ofmap_buffer: RTL
=======================

# conv1_ofmap_buffer

Output feature-map buffer placed directly downstream of convolution layer 1. It captures the pooled, truncated layer-1 results (CO channels of O_SIZE×O_SIZE signed words) into an internal single-port-style RAM, in channel-major order. Once a full frame is held, it streams the frame out to the layer-2 front end over a valid/ready interface. It decouples the bursty, per-channel pooled output from layer 2's consumption rate.

## Interface
Parameters:
- I_BW, 16, width of a stored word; equals layer-1 output width.
- CO, 4, number of layer-1 output channels.
- O_SIZE, 12, pooled map edge; one channel holds O_SIZE*O_SIZE words.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W ≥ CO*O_SIZE*O_SIZE (576).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- global_rst_n  in  1  asynchronous, active-low reset.
- user_reset  in  1  synchronous clear, active-high.
- i_data  in  I_BW  signed pooled result.
- i_valid  in  1  i_data valid this cycle (layer-1 enable).
- i_ch_end  in  1  one-cycle pulse: current channel complete.
- i_allch_end  in  1  level/pulse: layer 1 finished all channels.
- o_data  out  I_BW  signed stream word.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.
- o_last  out  1  high with the final word of the frame.
- o_full  out  1  high while the frame is held (READ state).
- o_done  out  1  one-cycle pulse after the last handshake.
- o_err  out  1  sticky protocol error flag.

## Operation
- States: FILL → READ → DONE → FILL.
- FILL:
  - Each i_valid writes i_data at addr = ch*O_SIZE*O_SIZE + pix, then pix increments.
  - i_ch_end clears pix and increments ch.
  - When i_valid and i_ch_end occur in the same cycle, the write completes at the old ch/pix, then the counters advance.
  - When ch reaches CO after an i_ch_end, the block enters READ.
  - i_allch_end asserted while ch < CO forces entry to READ and sets o_err.
- Channel overflow: an i_valid with pix == O_SIZE*O_SIZE is dropped and sets o_err.
- i_valid or i_ch_end arriving in READ or DONE is dropped and sets o_err; the frame contents are unaffected.
- READ:
  - Reads addresses 0 … CO*O_SIZE*O_SIZE-1 in order.
  - A word transfers when o_valid && i_ready.
  - o_data and o_valid hold stable while i_ready is low.
  - A RAM with 1-cycle synchronous read plus a 2-entry skid sustains one word per cycle when i_ready is held high.
  - o_last is asserted with word 575 (default parameters).
- DONE: lasts one cycle, with o_done=1; counters clear and the block returns to FILL.
- user_reset returns the block to FILL, clears all counters, o_err, o_valid and the skid. RAM contents are not cleared.
- o_err clears only on reset or user_reset.

## Timing
- Reset values (global_rst_n low, asynchronous):
  - State = FILL.
  - o_data=0, o_valid=0, o_last=0, o_full=0, o_done=0, o_err=0.
  - ch=0, pix=0.
- Write latency: 0 cycles; data is captured on the edge where i_valid is high.
- READ entry edge t: o_full=1 from t. First o_valid at t+2, provided i_ready is don't-care.
- With i_ready held high, the frame drains in CO*O_SIZE*O_SIZE consecutive cycles.
- o_done pulses on the cycle after the o_last handshake. o_full drops in the same cycle.
- A reset asserted mid-READ deasserts o_valid immediately (asynchronous). No partial handshake is completed.

## Configuration
- OFMAP_BUF_CLAMP_EN defined: negative i_data is stored as 0, as a guard against upstream ReLU bypass. o_err is not affected by clamping.
- OFMAP_BUF_CLAMP_EN undefined: i_data is stored unmodified, including negative values.

## Test plan
- Full frame: write 4×144 words with values = address, i_ch_end after each 144th word, i_ready=1 → o_valid at READ entry+2, stream 0…575 on consecutive cycles, o_last on 575, o_done one cycle later, o_err=0.
- Backpressure: same frame, i_ready toggled by a random 50% pattern → identical ordered sequence. o_data is held stable for every stalled cycle, with no drops or duplicates.
- Simultaneous event: the 144th i_valid coincides with i_ch_end → word stored at address 143; the next word goes to 144.
- Errors:
  - 145th i_valid in channel 0 → dropped, o_err=1.
  - i_allch_end after 2 channels → READ entered, o_err=1.
  - i_valid during READ → dropped, stream unchanged.
- Reset: global_rst_n low mid-READ at word 300 → o_valid=0 immediately. After release, a new full frame streams correctly from address 0. user_reset produces the same result synchronously.
- Clamp: write i_data=-5 (0xFFFB) → streamed as 0 with OFMAP_BUF_CLAMP_EN defined, and as 0xFFFB without it.

Source files
------------

// File: rtl/conv1_ofmap_buffer_if.sv
// rtl/conv1_ofmap_buffer_if.sv - layer-1 capture stream and layer-2 output stream of the ofmap buffer
interface conv1_ofmap_buffer_if #(
    parameter int I_BW = 16
);
    logic signed [I_BW-1:0] i_data;
    logic                   i_valid;
    logic                   i_ch_end;
    logic                   i_allch_end;
    logic signed [I_BW-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_last;

    modport slave (
        input  i_data, i_valid, i_ch_end, i_allch_end, i_ready,
        output o_data, o_valid, o_last
    );

    modport master (
        output i_data, i_valid, i_ch_end, i_allch_end, i_ready,
        input  o_data, o_valid, o_last
    );
endinterface

// File: rtl/conv1_ofmap_buffer.sv
// rtl/conv1_ofmap_buffer.sv - layer-1 ofmap frame buffer; OFMAP_BUF_CLAMP_EN stores negative words as 0
module conv1_ofmap_buffer #(
    parameter int I_BW   = 16,
    parameter int CO     = 4,
    parameter int O_SIZE = 12,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 user_reset,
    conv1_ofmap_buffer_if.slave  bus,
    output logic                 o_full,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int PIX   = O_SIZE * O_SIZE;
    localparam int TOTAL = CO * PIX;
    localparam int CH_W  = $clog2(CO + 1);
    localparam int PIX_W = $clog2(PIX + 1);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_FILL, S_READ, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [I_BW-1:0]   head_q, head_d;
    logic [I_BW-1:0]   tail_q, tail_d;

    logic [I_BW-1:0]   mem [2**ADDR_W];
    logic [I_BW-1:0]   ram_rdata;
    logic              wr_en, rd_en, pop;
    logic [ADDR_W-1:0] wr_addr;
    logic [I_BW-1:0]   wr_data;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pix_d     = pix_q;
        err_d     = err_q;
        rd_addr_d = rd_addr_q;
        out_cnt_d = out_cnt_q;
        rd_pend_d = 1'b0;
        cnt_d     = cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        pop       = (cnt_q != 2'd0) && bus.i_ready;
        wr_addr   = ADDR_W'(int'(ch_q) * PIX + int'(pix_q));
`ifdef OFMAP_BUF_CLAMP_EN
        wr_data   = bus.i_data[I_BW-1] ? '0 : bus.i_data;
`else
        wr_data   = bus.i_data;
`endif

        case (state_q)
            S_FILL: begin
                // A write coinciding with i_ch_end lands at the old ch/pix before the counters move
                if (bus.i_valid) begin
                    if (pix_q < PIX_W'(PIX)) begin
                        wr_en = 1'b1;
                        pix_d = pix_q + PIX_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (bus.i_ch_end) begin
                    pix_d = '0;
                    ch_d  = ch_q + CH_W'(1);
                end
                if (ch_d == CH_W'(CO)) begin
                    state_d = S_READ;
                end else if (bus.i_allch_end) begin
                    state_d = S_READ;
                    err_d   = 1'b1;
                end
            end
            S_READ: begin
                if (bus.i_valid || bus.i_ch_end) err_d = 1'b1;
                // Issue only while skid + in-flight read, net of this cycle's pop, leaves a free slot
                rd_en = (rd_addr_q < CNT_W'(TOTAL)) &&
                        ((int'(cnt_q) + int'(rd_pend_q) - int'(pop)) < 2);
                rd_pend_d = rd_en;
                if (rd_en) rd_addr_d = rd_addr_q + CNT_W'(1);
                if (pop) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_cnt_q == CNT_W'(TOTAL - 1)) state_d = S_DONE;
                end
            end
            default: begin
                if (bus.i_valid || bus.i_ch_end) err_d = 1'b1;
                state_d   = S_FILL;
                ch_d      = '0;
                pix_d     = '0;
                rd_addr_d = '0;
                out_cnt_d = '0;
            end
        endcase

        case ({pop, rd_pend_q})
            2'b01: begin
                if (cnt_q == 2'd0) begin
                    head_d = ram_rdata;
                    cnt_d  = 2'd1;
                end else begin
                    tail_d = ram_rdata;
                    cnt_d  = 2'd2;
                end
            end
            2'b10: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = ram_rdata;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_rdata;
                end
            end
            default: ;
        endcase

        if (user_reset) begin
            state_d   = S_FILL;
            ch_d      = '0;
            pix_d     = '0;
            err_d     = 1'b0;
            rd_addr_d = '0;
            out_cnt_d = '0;
            rd_pend_d = 1'b0;
            cnt_d     = 2'd0;
            head_d    = '0;
            tail_d    = '0;
            wr_en     = 1'b0;
            rd_en     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q   <= S_FILL;
            ch_q      <= '0;
            pix_q     <= '0;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
            out_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            cnt_q     <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            pix_q     <= pix_d;
            err_q     <= err_d;
            rd_addr_q <= rd_addr_d;
            out_cnt_q <= out_cnt_d;
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    // Frame RAM: single write port in FILL, 1-cycle synchronous read in READ
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) ram_rdata <= mem[rd_addr_q[ADDR_W-1:0]];
    end

    assign bus.o_data  = head_q;
    assign bus.o_valid = (cnt_q != 2'd0);
    assign bus.o_last  = (cnt_q != 2'd0) && (out_cnt_q == CNT_W'(TOTAL - 1));
    assign o_full      = (state_q == S_READ);
    assign o_done      = (state_q == S_DONE);
    assign o_err       = err_q;
endmodule
